i2s_clock_gen: RTL and testbench
================================

I2S_CLOCK_GEN -- requirements
Module: i2s_clock_gen

Interface
REQ-001 Parameter MCLK_HALF, default 5: clk cycles per mclk half-period (range 2..255).
REQ-002 Parameter BCLK_HALF, default 2: mclk half-periods per bclk half-period (range 1..15).
REQ-003 Parameter FRAME_BITS, default 64: bclk periods per lrclk frame (power of two, 16..256).
REQ-004 Parameter SETTLE_CYCLES, default 1024: clk cycles of stable lock before RUN.
REQ-005 clk  input  1  system clock; the block's only clock.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 pll_lock  input  1  PLL lock indication, already synchronous to clk.
REQ-008 rx_valid  input  1  level from the I2S transceiver, high while a received sample is held.
REQ-009 engine_ready  input  1  high when the DSP engine can accept a sample tick.
REQ-010 mclk  output  1  codec master clock.
REQ-011 bclk  output  1  I2S bit clock.
REQ-012 lrclk  output  1  I2S word select.
REQ-013 bclk_rise / bclk_fall  output  1 each  one-cycle strobes, high in the cycle in which the bclk register toggles 0->1 / 1->0.
REQ-014 frame_start  output  1  one-cycle strobe, high on the bclk_fall that sets the bit counter to 0.
REQ-015 run  output  1  high only in state RUN; downstream blocks use it as their release-from-reset.
REQ-016 codec_en  output  1  mirrors pll_lock, registered.
REQ-017 tick  output  1  one-cycle sample-tick strobe to the engine.
REQ-018 overrun  output  1  sticky; cleared only by reset.

Function
REQ-019 The block SHALL implement three states: IDLE, SETTLE and RUN.
REQ-020 IDLE: on pll_lock=1, go to SETTLE with the settle counter cleared.
REQ-021 SETTLE: count clk cycles while pll_lock=1; at SETTLE_CYCLES-1, go to RUN; on pll_lock=0, return to IDLE.
REQ-022 RUN: on pll_lock=0, go to IDLE in the next cycle.
REQ-023 Outside RUN, mclk, bclk, lrclk, all strobes and all divider and bit counters SHALL be held at 0.
REQ-024 mclk SHALL toggle on every MCLK_HALF-th clk cycle in RUN; its first toggle (0->1) falls MCLK_HALF cycles after RUN is entered.
REQ-025 bclk SHALL toggle in the same cycle as every BCLK_HALF-th mclk toggle.
REQ-026 The bit counter (log2(FRAME_BITS) bits) SHALL increment on each bclk_fall and wrap FRAME_BITS-1 -> 0 with no gap.
REQ-027 lrclk SHALL equal the bit counter MSB, i.e. it changes only on bclk_fall.
REQ-028 Defaults give mclk = clk/10, bclk = mclk/2 and lrclk = bclk/64.
REQ-029 tick SHALL pulse for exactly one cycle, one cycle after a 0->1 edge of rx_valid is seen in RUN.
REQ-030 A rx_valid level held high SHALL NOT produce further ticks.
REQ-031 If engine_ready=0 in the cycle tick is asserted, tick SHALL still pulse and overrun SHALL be set.
REQ-032 A rx_valid rising edge in the same cycle as the RUN->IDLE transition SHALL produce no tick.
REQ-033 All outputs SHALL be registered; there are no combinational paths from input to output.

Reset
REQ-034 With reset_n=0 at a clk edge, the state SHALL become IDLE and every counter SHALL clear.
REQ-035 Reset values SHALL be 0 for mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, run, codec_en, tick and overrun.
REQ-036 Reset asserted mid-frame SHALL take effect in the next cycle with no partial-period completion.
REQ-037 After reset release, the full IDLE -> SETTLE -> RUN sequence is required before any clock output toggles.

Structure
REQ-038 State encoding and the default divider constants SHALL live in the shared audio package i2s_pkg.
REQ-039 The divider chain (mclk, bclk, bit counter) SHALL be the single sub-module i2s_divider; the state machine and tick logic stay in i2s_clock_gen.

Verification
REQ-040 pll_lock=1 from reset release -> run rises exactly 1024 cycles after SETTLE entry; first mclk rise 5 cycles later.
REQ-041 Defaults in RUN -> mclk period 10 clk, bclk period 20 clk, lrclk period 1280 clk, frame_start once every 1280 clk, coincident with the lrclk 1->0 change.
REQ-042 pll_lock dropped at SETTLE cycle 500 -> return to IDLE with run never asserted; restore -> a full 1024-cycle settle occurs again.
REQ-043 rx_valid held high for 40 cycles, twice -> exactly two single-cycle ticks; engine_ready=0 during the second tick -> overrun=1 and it stays set.
REQ-044 reset_n=0 for 1 cycle at bit counter 37 -> all outputs 0 in the next cycle; state IDLE.
REQ-045 pll_lock=0 in RUN coincident with a rx_valid rise -> no tick; clocks low in the next cycle.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared audio constants, the clock generator state encoding and default divider settings.
package i2s_pkg;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam int DEF_MCLK_HALF     = 5;
   localparam int DEF_BCLK_HALF     = 2;
   localparam int DEF_FRAME_BITS    = 64;
   localparam int DEF_SETTLE_CYCLES = 1024;
endpackage

// File: rtl/i2s_divider.sv
// i2s_divider: mclk/bclk divider chain and frame bit counter, all held at zero while i_en is low.
module i2s_divider
   import i2s_pkg::*;
#(
   parameter int MCLK_HALF  = DEF_MCLK_HALF,
   parameter int BCLK_HALF  = DEF_BCLK_HALF,
   parameter int FRAME_BITS = DEF_FRAME_BITS
) (
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_mclk,
   output logic o_bclk,
   output logic o_lrclk,
   output logic o_bclk_rise,
   output logic o_bclk_fall,
   output logic o_frame_start
);
   localparam int BW = $clog2(FRAME_BITS);
   logic [7:0]    r_mcnt;
   logic [3:0]    r_bcnt;
   logic [BW-1:0] r_bit;
   logic          r_mclk, r_bclk, r_rise, r_fall, r_fs;
   logic          w_mtog, w_btog, w_fall;
   assign w_mtog = r_mcnt == 8'(MCLK_HALF - 1);
   assign w_btog = w_mtog && r_bcnt == 4'(BCLK_HALF - 1);
   assign w_fall = w_btog && r_bclk;
   // Leaving RUN clears everything at once, so no partial period is ever completed.
   always_ff @(posedge clk) begin
      if (!i_rst_n || !i_en) begin
         r_mcnt <= '0;
         r_bcnt <= '0;
         r_bit  <= '0;
         r_mclk <= 1'b0;
         r_bclk <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         r_fs   <= 1'b0;
      end else begin
         r_mcnt <= w_mtog ? '0 : r_mcnt + 8'd1;
         r_mclk <= r_mclk ^ w_mtog;
         r_bcnt <= w_btog ? '0 : r_bcnt + 4'(w_mtog);
         r_bclk <= r_bclk ^ w_btog;
         r_rise <= w_btog && !r_bclk;
         r_fall <= w_fall;
         r_bit  <= r_bit + BW'(w_fall);
         r_fs   <= w_fall && r_bit == BW'(FRAME_BITS - 1);
      end
   end
   assign o_mclk        = r_mclk;
   assign o_bclk        = r_bclk;
   assign o_lrclk       = r_bit[BW-1];
   assign o_bclk_rise   = r_rise;
   assign o_bclk_fall   = r_fall;
   assign o_frame_start = r_fs;
endmodule

// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: PLL-lock sequencer (IDLE/SETTLE/RUN) gating the I2S divider chain, plus sample-tick and overrun logic.
module i2s_clock_gen
   import i2s_pkg::*;
#(
   parameter int MCLK_HALF     = DEF_MCLK_HALF,
   parameter int BCLK_HALF     = DEF_BCLK_HALF,
   parameter int FRAME_BITS    = DEF_FRAME_BITS,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pll_lock,
   input  logic rx_valid,
   input  logic engine_ready,
   output logic mclk,
   output logic bclk,
   output logic lrclk,
   output logic bclk_rise,
   output logic bclk_fall,
   output logic frame_start,
   output logic run,
   output logic codec_en,
   output logic tick,
   output logic overrun
);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   logic [1:0]    r_state;
   logic [SW-1:0] r_scnt;
   logic          r_run, r_codec_en, r_rx_d, r_tick, r_overrun;
   logic [1:0]    w_next;
   logic          w_run;
   always_comb
      w_next = !pll_lock ? ST_IDLE :
               r_state == ST_RUN ? ST_RUN :
               r_state == ST_SETTLE ? (r_scnt == SW'(SETTLE_CYCLES - 1) ? ST_RUN : ST_SETTLE) :
               ST_SETTLE;
   // Staying in RUN this cycle and next; the exit cycle counts as outside RUN.
   assign w_run = r_state == ST_RUN && w_next == ST_RUN;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_scnt     <= '0;
         r_run      <= 1'b0;
         r_codec_en <= 1'b0;
         r_rx_d     <= 1'b0;
         r_tick     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_scnt     <= (r_state == ST_SETTLE && w_next == ST_SETTLE) ? r_scnt + 1'b1 : '0;
         r_run      <= w_next == ST_RUN;
         r_codec_en <= pll_lock;
         r_rx_d     <= rx_valid;
         r_tick     <= w_run && rx_valid && !r_rx_d;
         r_overrun  <= r_overrun || (r_tick && !engine_ready);
      end
   end
   i2s_divider #(
      .MCLK_HALF (MCLK_HALF),
      .BCLK_HALF (BCLK_HALF),
      .FRAME_BITS(FRAME_BITS)
   ) u_div (
      .clk          (clk),
      .i_rst_n      (reset_n),
      .i_en         (w_run),
      .o_mclk       (mclk),
      .o_bclk       (bclk),
      .o_lrclk      (lrclk),
      .o_bclk_rise  (bclk_rise),
      .o_bclk_fall  (bclk_fall),
      .o_frame_start(frame_start)
   );
   assign run      = r_run;
   assign codec_en = r_codec_en;
   assign tick     = r_tick;
   assign overrun  = r_overrun;
endmodule

// File: tb/tb_i2s_clock_gen.sv
// tb_i2s_clock_gen: directed scenarios for the I2S clock generator with hand-computed timing expectations.
module tb_i2s_clock_gen;
   logic clk = 1'b0;
   logic reset_n, pll_lock, rx_valid, engine_ready;
   logic mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, run, codec_en, tick, overrun;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   i2s_clock_gen dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pll_lock    (pll_lock),
      .rx_valid    (rx_valid),
      .engine_ready(engine_ready),
      .mclk        (mclk),
      .bclk        (bclk),
      .lrclk       (lrclk),
      .bclk_rise   (bclk_rise),
      .bclk_fall   (bclk_fall),
      .frame_start (frame_start),
      .run         (run),
      .codec_en    (codec_en),
      .tick        (tick),
      .overrun     (overrun)
   );

   function automatic logic [9:0] all_outs();
      return {mclk, bclk, lrclk, bclk_rise, bclk_fall, frame_start, run, codec_en, tick, overrun};
   endfunction

   function automatic logic sig(input int s);
      return s == 0 ? mclk : s == 1 ? bclk : s == 2 ? lrclk : frame_start;
   endfunction

   // Negedges until signal s changes to want; -1 if the bound expires.
   task automatic wait_edge(input int s, input logic want, input int limit, output int n);
      logic p;
      bit   done;
      p = sig(s);
      n = 0;
      done = 1'b0;
      while (!done && n < limit) begin
         @(negedge clk);
         n++;
         done = sig(s) === want && p !== want;
         p = sig(s);
      end
      if (!done) n = -1;
   endtask

   // Raise pll_lock and count negedges until run is seen, plus negedges with any clock high.
   task automatic wait_run(output int n, output int n_clk);
      pll_lock = 1'b1;
      n = 0;
      n_clk = 0;
      while (run !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
         if ((mclk | bclk | lrclk) === 1'b1) n_clk++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      pll_lock = 1'b0;
      rx_valid = 1'b0;
      engine_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if (all_outs() !== 10'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected %b", all_outs(), 10'd0);
      end
   endtask

   task automatic test_settle();
      int n, nc;
      reset_n = 1'b1;
      wait_run(n, nc);
      n_vec++;
      if (n !== 1025) begin n_err++; $display("FAIL settle_delay: got %0d expected %0d", n, 1025); end
      n_vec++;
      if (nc !== 0) begin n_err++; $display("FAIL settle_quiet: got %0d expected %0d", nc, 0); end
      n_vec++;
      if (codec_en !== 1'b1) begin n_err++; $display("FAIL codec_en: got %b expected 1", codec_en); end
      wait_edge(0, 1'b1, 50, n);
      n_vec++;
      if (n !== 5) begin n_err++; $display("FAIL first_mclk_rise: got %0d expected %0d", n, 5); end
   endtask

   task automatic test_clocks();
      int n;
      wait_edge(0, 1'b1, 50, n);
      wait_edge(0, 1'b1, 50, n);
      n_vec++;
      if (n !== 10) begin n_err++; $display("FAIL mclk_period: got %0d expected %0d", n, 10); end
      wait_edge(1, 1'b1, 50, n);
      n_vec++;
      if (bclk_rise !== 1'b1) begin n_err++; $display("FAIL bclk_rise_strobe: got %b expected 1", bclk_rise); end
      wait_edge(1, 1'b1, 50, n);
      n_vec++;
      if (n !== 20) begin n_err++; $display("FAIL bclk_period: got %0d expected %0d", n, 20); end
      wait_edge(1, 1'b0, 50, n);
      n_vec++;
      if (n !== 10 || bclk_fall !== 1'b1) begin
         n_err++;
         $display("FAIL bclk_fall_strobe: got n=%0d strobe=%b expected n=10 strobe=1", n, bclk_fall);
      end
      @(negedge clk);
      n_vec++;
      if (bclk_fall !== 1'b0) begin n_err++; $display("FAIL bclk_fall_width: got %b expected 0", bclk_fall); end
      wait_edge(2, 1'b1, 1400, n);
      wait_edge(2, 1'b1, 1400, n);
      n_vec++;
      if (n !== 1280) begin n_err++; $display("FAIL lrclk_period: got %0d expected %0d", n, 1280); end
      wait_edge(2, 1'b0, 1400, n);
      n_vec++;
      if (n !== 640) begin n_err++; $display("FAIL lrclk_high: got %0d expected %0d", n, 640); end
      n_vec++;
      if (frame_start !== 1'b1) begin n_err++; $display("FAIL frame_at_lrclk_fall: got %b expected 1", frame_start); end
      wait_edge(3, 1'b1, 1400, n);
      n_vec++;
      if (n !== 1280 || lrclk !== 1'b0) begin
         n_err++;
         $display("FAIL frame_period: got n=%0d lrclk=%b expected n=1280 lrclk=0", n, lrclk);
      end
      @(negedge clk);
      n_vec++;
      if (frame_start !== 1'b0) begin n_err++; $display("FAIL frame_width: got %b expected 0", frame_start); end
   endtask

   task automatic test_tick();
      int cnt, first;
      rx_valid = 1'b1;
      engine_ready = 1'b1;
      cnt = 0;
      first = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (tick === 1'b1) begin cnt++; if (first < 0) first = i; end
      end
      rx_valid = 1'b0;
      repeat (10) @(negedge clk);
      n_vec++;
      if (cnt !== 1) begin n_err++; $display("FAIL tick_count1: got %0d expected %0d", cnt, 1); end
      n_vec++;
      if (first !== 1) begin n_err++; $display("FAIL tick_latency: got %0d expected %0d", first, 1); end
      n_vec++;
      if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
      engine_ready = 1'b0;
      rx_valid = 1'b1;
      cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (tick === 1'b1) cnt++;
      end
      rx_valid = 1'b0;
      engine_ready = 1'b1;
      repeat (10) @(negedge clk);
      n_vec++;
      if (cnt !== 1) begin n_err++; $display("FAIL tick_count2: got %0d expected %0d", cnt, 1); end
      n_vec++;
      if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", overrun); end
      repeat (50) @(negedge clk);
      n_vec++;
      if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_run_exit_tick();
      int n, cnt;
      wait_edge(0, 1'b1, 20, n);
      pll_lock = 1'b0;
      rx_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({mclk, bclk, lrclk, run, tick} !== 5'd0) begin
         n_err++;
         $display("FAIL exit_outputs: got %b expected %b", {mclk, bclk, lrclk, run, tick}, 5'd0);
      end
      cnt = 0;
      repeat (5) begin @(negedge clk); if (tick === 1'b1) cnt++; end
      n_vec++;
      if (cnt !== 0) begin n_err++; $display("FAIL exit_tick: got %0d expected %0d", cnt, 0); end
      n_vec++;
      if (codec_en !== 1'b0 || overrun !== 1'b1) begin
         n_err++;
         $display("FAIL exit_flags: got codec_en=%b overrun=%b expected codec_en=0 overrun=1", codec_en, overrun);
      end
      rx_valid = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_lock_drop();
      int n, nc, cnt;
      cnt = 0;
      pll_lock = 1'b1;
      repeat (501) begin @(negedge clk); if (run !== 1'b0) cnt++; end
      pll_lock = 1'b0;
      repeat (600) begin @(negedge clk); if (run !== 1'b0) cnt++; end
      n_vec++;
      if (cnt !== 0) begin n_err++; $display("FAIL drop_run: got %0d expected %0d", cnt, 0); end
      wait_run(n, nc);
      n_vec++;
      if (n !== 1025 || nc !== 0) begin
         n_err++;
         $display("FAIL resettle: got n=%0d clk_high=%0d expected n=1025 clk_high=0", n, nc);
      end
   endtask

   task automatic test_reset_mid();
      int n, nc;
      repeat (745) @(negedge clk);
      n_vec++;
      if (lrclk !== 1'b1 || run !== 1'b1) begin
         n_err++;
         $display("FAIL bit37_state: got lrclk=%b run=%b expected lrclk=1 run=1", lrclk, run);
      end
      reset_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (all_outs() !== 10'd0) begin
         n_err++;
         $display("FAIL midframe_reset: got %b expected %b", all_outs(), 10'd0);
      end
      reset_n = 1'b1;
      wait_run(n, nc);
      n_vec++;
      if (n !== 1025 || nc !== 0) begin
         n_err++;
         $display("FAIL post_reset_settle: got n=%0d clk_high=%0d expected n=1025 clk_high=0", n, nc);
      end
   endtask

   initial begin
      test_reset();
      test_settle();
      test_clocks();
      test_tick();
      test_run_exit_tick();
      test_lock_drop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
